inst_fetcher: RTL and testbench

- Front-end instruction fetch stage sitting directly upstream of the memory controller.
- Holds the PC and a direct-mapped instruction cache with one 32-bit instruction per line.
- Delivers one instruction per cycle to the decoder on a cache hit; on a miss, issues a single fetch request to the memory controller and fills the line from the reply.
- Redirected by the reorder buffer on a mispredict or jump.

---
 rtl/inst_fetcher.sv | 204 ++++++++++++++++++++
 tb/tb_inst_fetcher.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// inst_fetcher
//
// Front-end instruction fetch stage. It holds the PC and a direct-mapped
// instruction cache with one 32-bit instruction per line. On a hit, one
// instruction per cycle goes to the decoder. On a miss, one fetch request goes
// to the memory controller and the reply fills the line. The line is emitted
// by the lookup that follows the fill. The reorder buffer can redirect the PC
// at any time.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-low reset
//   rdy            global enable; 0 holds all state and squashes both strobes
//   mc_need_fetch  one-cycle fetch request to the memory controller
//   mc_fetch_pc    request address, valid while mc_need_fetch=1
//   mc_valid       one-cycle reply strobe from the memory controller
//   mc_inst        reply instruction, valid with mc_valid
//   dec_full       decoder cannot accept an instruction this cycle
//   out_valid      instruction strobe to the decoder
//   out_inst       instruction
//   out_pc         address of out_inst
//   rob_jump       redirect request (mispredict / jump)
//   rob_target     redirect PC; the two low bits are ignored
// -----------------------------------------------------------------------------
module inst_fetcher #(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mc_need_fetch,
  output logic [31:0] mc_fetch_pc,
  input  logic        mc_valid,
  input  logic [31:0] mc_inst,
  input  logic        dec_full,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        rob_jump,
  input  logic [31:0] rob_target
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {
    S_IDLE = 1'b0,  // looking up the PC every cycle
    S_WAIT = 1'b1   // one request outstanding, waiting for the reply
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [31:0]           r_pc;
  logic [31:0]           r_miss_pc;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES];

  logic                  r_need_fetch;
  logic [31:0]           r_fetch_pc;
  logic                  r_out_valid;
  logic [31:0]           r_out_inst;
  logic [31:0]           r_out_pc;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_miss_idx;
  logic [TAG_BITS-1:0]   w_miss_tag;
  logic                  w_hit;
  logic [31:0]           w_target;

  logic [31:0]           w_pc_nxt;
  logic [31:0]           w_miss_pc_nxt;
  logic                  w_fill;
  logic                  w_need_nxt;
  logic [31:0]           w_fetch_pc_nxt;
  logic                  w_out_valid_nxt;
  logic [31:0]           w_out_inst_nxt;
  logic [31:0]           w_out_pc_nxt;

  // Lookup is purely combinational from the PC register.
  assign w_idx      = r_pc[INDEX_BITS+1:2];
  assign w_tag      = r_pc[31:INDEX_BITS+2];
  assign w_miss_idx = r_miss_pc[INDEX_BITS+1:2];
  assign w_miss_tag = r_miss_pc[31:INDEX_BITS+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_target   = rob_target & 32'hFFFF_FFFC;

  assign mc_need_fetch = r_need_fetch;
  assign mc_fetch_pc   = r_fetch_pc;
  assign out_valid     = r_out_valid;
  assign out_inst      = r_out_inst;
  assign out_pc        = r_out_pc;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    w_state_nxt = r_state;
    if (rdy) begin
      case (r_state)
        // Only a genuine miss leaves IDLE. A redirect or a stalled decoder
        // keeps the lookup going.
        S_IDLE:  if (!rob_jump && !dec_full && !w_hit) w_state_nxt = S_WAIT;
        // The reply always ends the wait, including after a redirect.
        S_WAIT:  if (mc_valid) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output and datapath next values (all outputs registered)
  // ---------------------------------------------------------------------------
  always_comb begin : output_logic
    // NOTE: every signal gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    w_need_nxt      = 1'b0;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_out_valid_nxt = 1'b0;
    w_out_inst_nxt  = r_out_inst;
    w_out_pc_nxt    = r_out_pc;
    w_pc_nxt        = r_pc;
    w_miss_pc_nxt   = r_miss_pc;
    w_fill          = 1'b0;
    if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (rob_jump) begin
            w_pc_nxt = w_target;
          end else if (!dec_full) begin
            if (w_hit) begin
              w_out_valid_nxt = 1'b1;
              w_out_inst_nxt  = r_data[w_idx];
              w_out_pc_nxt    = r_pc;
              w_pc_nxt        = r_pc + 32'd4;  // wraps naturally at 2^32
            end else begin
              w_need_nxt     = 1'b1;
              w_fetch_pc_nxt = r_pc;
              w_miss_pc_nxt  = r_pc;
            end
          end
        end
        S_WAIT: begin
          // The reply is written even after a redirect, because its address
          // is still genuine. It is never emitted here; the next IDLE lookup
          // decides what goes to the decoder.
          w_fill = mc_valid;
          if (rob_jump) w_pc_nxt = w_target;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin : datapath_regs
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_miss_pc    <= '0;
      r_valid      <= '0;
      r_need_fetch <= 1'b0;
      r_fetch_pc   <= '0;
      r_out_valid  <= 1'b0;
      r_out_inst   <= '0;
      r_out_pc     <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_miss_pc    <= w_miss_pc_nxt;
      r_need_fetch <= w_need_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_inst   <= w_out_inst_nxt;
      r_out_pc     <= w_out_pc_nxt;
      if (w_fill) r_valid[w_miss_idx] <= 1'b1;
    end
  end

  // NOTE: the tag and data arrays are deliberately not reset. The valid bits
  // gate every use, and leaving the arrays reset-free lets them map to RAM.
  always_ff @(posedge clk) begin : cache_arrays
    if (w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= mc_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_inst_fetcher
//
// Self-checking bench for inst_fetcher. It has three parts:
//   - a table of per-cycle vectors: cold start, streaming, redirect, stall and
//     pause;
//   - hand-written sequences: reset during a miss, redirect while waiting,
//     index conflict and PC wrap;
//   - randomized traffic checked against a reference model. The model treats
//     the cache as a map from line index to the resident address, and memory
//     as a fixed function of the address.
// -----------------------------------------------------------------------------
module tb_inst_fetcher;

  localparam int IB = 6;

  localparam logic [31:0] I0   = 32'h0000_0013;
  localparam logic [31:0] I4   = 32'h0010_0093;
  localparam logic [31:0] I8   = 32'h0020_0113;
  localparam logic [31:0] IC   = 32'h0030_0193;
  localparam logic [31:0] I10  = 32'h0040_0213;
  localparam logic [31:0] I14  = 32'h0050_0293;
  localparam logic [31:0] I40  = 32'h0400_0413;
  localparam logic [31:0] I100 = 32'h1000_0513;
  localparam logic [31:0] IW   = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mc_need_fetch;
  logic [31:0] mc_fetch_pc;
  logic        mc_valid;
  logic [31:0] mc_inst;
  logic        dec_full;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        rob_jump;
  logic [31:0] rob_target;

  always #5 clk = ~clk;

  inst_fetcher #(.INDEX_BITS(IB), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .mc_need_fetch (mc_need_fetch),
    .mc_fetch_pc   (mc_fetch_pc),
    .mc_valid      (mc_valid),
    .mc_inst       (mc_inst),
    .dec_full      (dec_full),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .rob_jump      (rob_jump),
    .rob_target    (rob_target)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          rdy;
    bit          df;
    bit          mv;
    logic [31:0] inst;
    bit          j;
    logic [31:0] tgt;
    bit          en;
    logic [31:0] efpc;
    bit          eov;
    logic [31:0] ei;
    logic [31:0] ep;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all outputs. The address and instruction fields are only
  // meaningful while their strobe is expected.
  task automatic chk_out(input string name, input bit en, input logic [31:0] efpc,
                         input bit eov, input logic [31:0] ei, input logic [31:0] ep);
    check({name, ".need"}, {31'b0, mc_need_fetch}, {31'b0, en});
    if (en) check({name, ".fetch_pc"}, mc_fetch_pc, efpc);
    check({name, ".out_valid"}, {31'b0, out_valid}, {31'b0, eov});
    if (eov) begin
      check({name, ".out_inst"}, out_inst, ei);
      check({name, ".out_pc"}, out_pc, ep);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle for sampling.
  task automatic step(input bit r, input bit df, input bit mv, input logic [31:0] inst,
                      input bit j, input logic [31:0] tgt);
    rdy        = r;
    dec_full   = df;
    mc_valid   = mv;
    mc_inst    = inst;
    rob_jump   = j;
    rob_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic sc(input string name, input bit r, input bit df, input bit mv,
                    input logic [31:0] inst, input bit j, input logic [31:0] tgt,
                    input bit en, input logic [31:0] efpc, input bit eov,
                    input logic [31:0] ei, input logic [31:0] ep);
    step(r, df, mv, inst, j, tgt);
    chk_out(name, en, efpc, eov, ei, ep);
  endtask

  task automatic add(input bit r, input bit df, input bit mv, input logic [31:0] inst,
                     input bit j, input logic [31:0] tgt, input bit en,
                     input logic [31:0] efpc, input bit eov, input logic [31:0] ei,
                     input logic [31:0] ep);
    vec_t v;
    v.rdy = r;  v.df = df;    v.mv = mv;   v.inst = inst; v.j = j; v.tgt = tgt;
    v.en  = en; v.efpc = efpc; v.eov = eov; v.ei = ei;    v.ep = ep;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_vals(input string name);
    check({name, ".need"},     {31'b0, mc_need_fetch}, 32'd0);
    check({name, ".fetch_pc"}, mc_fetch_pc, 32'd0);
    check({name, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    check({name, ".out_inst"}, out_inst, 32'd0);
    check({name, ".out_pc"},   out_pc, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the cache is "which address lives at each index"; the
  // memory is a fixed function of the address.
  // ---------------------------------------------------------------------------
  logic [31:0] m_owner[int];
  logic [31:0] m_pc;
  logic [31:0] m_miss;
  bit          m_wait;
  bit          e_need;
  bit          e_ov;
  logic [31:0] e_fpc;
  logic [31:0] e_inst;
  logic [31:0] e_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 4) % (1 << IB));
  endfunction

  function automatic bit resident(input logic [31:0] a);
    return m_owner.exists(line_of(a)) && (m_owner[line_of(a)] == a);
  endfunction

  task automatic model_reset();
    m_owner.delete();
    m_pc   = 32'h0;
    m_miss = 32'h0;
    m_wait = 1'b0;
    e_fpc  = 32'h0;
    e_inst = 32'h0;
    e_pc   = 32'h0;
  endtask

  task automatic model_step(input bit r, input bit df, input bit mv, input bit j,
                            input logic [31:0] tgt);
    e_need = 1'b0;
    e_ov   = 1'b0;
    if (r) begin
      if (!m_wait) begin
        if (j) begin
          m_pc = tgt & ~32'h3;
        end else if (!df) begin
          if (resident(m_pc)) begin
            e_ov   = 1'b1;
            e_inst = mem_word(m_pc);
            e_pc   = m_pc;
            m_pc   = m_pc + 32'd4;
          end else begin
            e_need = 1'b1;
            e_fpc  = m_pc;
            m_miss = m_pc;
            m_wait = 1'b1;
          end
        end
      end else begin
        if (mv) begin
          m_owner[line_of(m_miss)] = m_miss;
          m_wait = 1'b0;
        end
        if (j) m_pc = tgt & ~32'h3;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rdy = 1'b1; dec_full = 1'b0; mc_valid = 1'b0; mc_inst = '0;
    rob_jump = 1'b0; rob_target = '0;

    // ---- Per-cycle vectors from reset release ------------------------------
    //  rdy df mv inst  j tgt       | need fpc        ov inst  pc
    add(1, 0, 0, 0,    0, 0,        1, 32'h0,      0, 0,    0);      // cold miss at 0
    add(1, 0, 0, 0,    0, 0,        0, 0,          0, 0,    0);
    add(1, 0, 0, 0,    0, 0,        0, 0,          0, 0,    0);
    add(1, 0, 0, 0,    0, 0,        0, 0,          0, 0,    0);
    add(1, 0, 1, I0,   0, 0,        0, 0,          0, 0,    0);      // reply
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I0,   32'h0);  // 2nd cycle after reply
    add(1, 0, 0, 0,    0, 0,        1, 32'h4,      0, 0,    0);
    add(1, 0, 1, I4,   0, 0,        0, 0,          0, 0,    0);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I4,   32'h4);
    add(1, 0, 0, 0,    0, 0,        1, 32'h8,      0, 0,    0);
    add(1, 0, 1, I8,   0, 0,        0, 0,          0, 0,    0);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I8,   32'h8);
    add(1, 0, 0, 0,    0, 0,        1, 32'hC,      0, 0,    0);
    add(1, 0, 1, IC,   0, 0,        0, 0,          0, 0,    0);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, IC,   32'hC);
    add(1, 0, 0, 0,    1, 32'h0,    0, 0,          0, 0,    0);      // jump beats miss at 0x10
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I0,   32'h0);  // streaming hits
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I4,   32'h4);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I8,   32'h8);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, IC,   32'hC);
    add(1, 0, 0, 0,    0, 0,        1, 32'h10,     0, 0,    0);
    add(1, 0, 0, 0,    1, 32'h3,    0, 0,          0, 0,    0);      // unaligned redirect in WAIT
    add(1, 0, 1, I10,  0, 0,        0, 0,          0, 0,    0);      // fill 0x10, not emitted
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I0,   32'h0);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I4,   32'h4);
    add(1, 1, 0, 0,    0, 0,        0, 0,          0, 0,    0);      // decoder full x3
    add(1, 1, 0, 0,    0, 0,        0, 0,          0, 0,    0);
    add(1, 1, 0, 0,    0, 0,        0, 0,          0, 0,    0);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I8,   32'h8);  // no skip / duplicate
    add(0, 0, 0, 0,    0, 0,        0, 0,          0, 0,    0);      // pause x2
    add(0, 0, 0, 0,    0, 0,        0, 0,          0, 0,    0);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, IC,   32'hC);
    add(1, 0, 0, 0,    0, 0,        0, 0,          1, I10,  32'h10); // line filled during WAIT
    add(1, 0, 0, 0,    0, 0,        1, 32'h14,     0, 0,    0);      // now waiting on 0x14

    @(posedge clk); #1;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].rdy, vecs[i].df, vecs[i].mv, vecs[i].inst, vecs[i].j, vecs[i].tgt);
      chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].efpc, vecs[i].eov,
              vecs[i].ei, vecs[i].ep);
    end

    // ---- Reset in the middle of a miss, then a stray reply -----------------
    rst = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    step(1, 0, 1, 32'hDEAD_BEEF, 0, 0);
    rst = 1'b1;
    sc("rst_a1", 1, 0, 1, 32'hDEAD_BEEF, 0, 0,        1, 32'h0,  0, 0, 0);
    sc("rst_a2", 1, 0, 0, 0, 0, 0,                    0, 0,      0, 0, 0);
    sc("rst_a3", 1, 0, 1, I0, 0, 0,                   0, 0,      0, 0, 0);
    sc("rst_a4", 1, 0, 0, 0, 0, 0,                    0, 0,      1, I0, 32'h0);
    sc("rst_a5", 1, 0, 0, 0, 0, 0,                    1, 32'h4,  0, 0, 0);   // valid bits were cleared
    sc("rst_a6", 1, 0, 1, I4, 0, 0,                   0, 0,      0, 0, 0);
    sc("rst_a7", 1, 0, 0, 0, 0, 0,                    0, 0,      1, I4, 32'h4);
    sc("rst_a8", 1, 0, 0, 0, 1, 32'h14,               0, 0,      0, 0, 0);
    sc("rst_a9", 1, 0, 0, 0, 0, 0,                    1, 32'h14, 0, 0, 0);   // stray reply not cached
    sc("rst_a10", 1, 0, 1, I14, 0, 0,                 0, 0,      0, 0, 0);
    sc("rst_a11", 1, 0, 0, 0, 0, 0,                   0, 0,      1, I14, 32'h14);

    // ---- Redirect while waiting --------------------------------------------
    sc("redir_b1", 1, 0, 0, 0, 1, 32'h40,             0, 0,       0, 0, 0);
    sc("redir_b2", 1, 0, 0, 0, 0, 0,                  1, 32'h40,  0, 0, 0);
    sc("redir_b3", 1, 0, 0, 0, 0, 0,                  0, 0,       0, 0, 0);
    sc("redir_b4", 1, 0, 0, 0, 1, 32'h100,            0, 0,       0, 0, 0);
    sc("redir_b5", 1, 0, 1, I40, 0, 0,                0, 0,       0, 0, 0);
    sc("redir_b6", 1, 0, 0, 0, 0, 0,                  1, 32'h100, 0, 0, 0);  // 0x40 not emitted
    sc("redir_b7", 1, 0, 1, I100, 0, 0,               0, 0,       0, 0, 0);
    sc("redir_b8", 1, 0, 0, 0, 0, 0,                  0, 0,       1, I100, 32'h100);
    sc("redir_b9", 1, 0, 0, 0, 1, 32'h40,             0, 0,       0, 0, 0);
    sc("redir_b10", 1, 0, 0, 0, 0, 0,                 0, 0,       1, I40, 32'h40);

    // ---- Index conflict: 0x000 / 0x100 / 0x000 all miss --------------------
    sc("conf_c1", 1, 0, 0, 0, 1, 32'h0,               0, 0,       0, 0, 0);
    sc("conf_c2", 1, 0, 0, 0, 0, 0,                   1, 32'h0,   0, 0, 0);
    sc("conf_c3", 1, 0, 1, I0, 0, 0,                  0, 0,       0, 0, 0);
    sc("conf_c4", 1, 0, 0, 0, 0, 0,                   0, 0,       1, I0, 32'h0);
    sc("conf_c5", 1, 0, 0, 0, 1, 32'h100,             0, 0,       0, 0, 0);
    sc("conf_c6", 1, 0, 0, 0, 0, 0,                   1, 32'h100, 0, 0, 0);
    sc("conf_c7", 1, 0, 1, I100, 0, 0,                0, 0,       0, 0, 0);
    sc("conf_c8", 1, 0, 0, 0, 0, 0,                   0, 0,       1, I100, 32'h100);
    sc("conf_c9", 1, 0, 0, 0, 1, 32'h0,               0, 0,       0, 0, 0);
    sc("conf_c10", 1, 0, 0, 0, 0, 0,                  1, 32'h0,   0, 0, 0);
    sc("conf_c11", 1, 0, 1, I0, 0, 0,                 0, 0,       0, 0, 0);
    sc("conf_c12", 1, 0, 0, 0, 0, 0,                  0, 0,       1, I0, 32'h0);

    // ---- PC wrap at the top of the address space ---------------------------
    sc("wrap_w1", 1, 0, 0, 0, 1, 32'hFFFF_FFFF,       0, 0,            0, 0, 0);
    sc("wrap_w2", 1, 0, 0, 0, 0, 0,                   1, 32'hFFFF_FFFC, 0, 0, 0);
    sc("wrap_w3", 1, 0, 1, IW, 0, 0,                  0, 0,            0, 0, 0);
    sc("wrap_w4", 1, 0, 0, 0, 0, 0,                   0, 0,            1, IW, 32'hFFFF_FFFC);
    sc("wrap_w5", 1, 0, 0, 0, 0, 0,                   0, 0,            1, I0, 32'h0);

    // ---- Randomized traffic against the reference model --------------------
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      bit          r;
      bit          df;
      bit          mv;
      bit          j;
      logic [31:0] inst;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 9) != 0);
      df  = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) tgt = tgt + 32'h100;
      if (m_wait) begin
        mv   = ($urandom_range(0, 2) == 0);
        inst = mem_word(m_miss);
      end else begin
        // A stray reply outside a miss must never reach the cache.
        mv   = ($urandom_range(0, 7) == 0);
        inst = 32'hBAD0_0000 | $urandom_range(0, 65535);
      end
      model_step(r, df, mv, j, tgt);
      step(r, df, mv, inst, j, tgt);
      chk_out($sformatf("rand%0d", c), e_need, e_fpc, e_ov, e_inst, e_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
